// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between three requesters.
// Issues at most one registered access per cycle and steers 1-cycle read data back to its issuer.
module mem_port_arbiter #(
    parameter int RAM_WIDTH     = 16,
    parameter int RAM_ADDR_BITS = 15
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [2:0]                 req,
    input  logic [2:0]                 req_we,
    input  logic [3*RAM_ADDR_BITS-1:0] req_addr,
    input  logic [3*RAM_WIDTH-1:0]     req_wdata,
    output logic [2:0]                 gnt,
    output logic [2:0]                 rvalid,
    output logic [RAM_WIDTH-1:0]       rdata,
    output logic                       mem_en,
    output logic                       mem_we,
    output logic [RAM_ADDR_BITS-1:0]   mem_addr,
    output logic [RAM_WIDTH-1:0]       mem_din,
    input  logic [RAM_WIDTH-1:0]       mem_dout
);

    logic [1:0]               r_ptr;
    logic [2:0]               r_gnt;
    logic                     r_mem_en;
    logic                     r_mem_we;
    logic [RAM_ADDR_BITS-1:0] r_mem_addr;
    logic [RAM_WIDTH-1:0]     r_mem_din;
    logic [2:0]               r_rvalid;

    logic [2:0]               w_elig;
    logic                     w_win_vld;
    logic [1:0]               w_win_idx;
    logic [2:0]               w_win_onehot;
    logic [1:0]               w_ptr_nxt;
    logic                     w_sel_we;
    logic [RAM_ADDR_BITS-1:0] w_sel_addr;
    logic [RAM_WIDTH-1:0]     w_sel_wdata;

    // The requester granted this cycle still shows req high; masking it avoids a double grant.
    assign w_elig    = req & ~r_gnt;
    assign w_win_vld = |w_elig;

    always_comb begin
        w_win_idx = 2'd0;
        case (r_ptr)
            2'd1: begin
                if (w_elig[1])      w_win_idx = 2'd1;
                else if (w_elig[2]) w_win_idx = 2'd2;
                else                w_win_idx = 2'd0;
            end
            2'd2: begin
                if (w_elig[2])      w_win_idx = 2'd2;
                else if (w_elig[0]) w_win_idx = 2'd0;
                else                w_win_idx = 2'd1;
            end
            default: begin
                if (w_elig[0])      w_win_idx = 2'd0;
                else if (w_elig[1]) w_win_idx = 2'd1;
                else                w_win_idx = 2'd2;
            end
        endcase
    end

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        case (w_win_idx)
            2'd1: begin
                w_sel_we    = req_we[1];
                w_sel_addr  = req_addr[RAM_ADDR_BITS +: RAM_ADDR_BITS];
                w_sel_wdata = req_wdata[RAM_WIDTH +: RAM_WIDTH];
            end
            2'd2: begin
                w_sel_we    = req_we[2];
                w_sel_addr  = req_addr[2*RAM_ADDR_BITS +: RAM_ADDR_BITS];
                w_sel_wdata = req_wdata[2*RAM_WIDTH +: RAM_WIDTH];
            end
            default: begin
                w_sel_we    = req_we[0];
                w_sel_addr  = req_addr[0 +: RAM_ADDR_BITS];
                w_sel_wdata = req_wdata[0 +: RAM_WIDTH];
            end
        endcase
    end

    assign w_win_onehot = 3'b001 << w_win_idx;
    assign w_ptr_nxt    = (w_win_idx == 2'd2) ? 2'd0 : w_win_idx + 2'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr      <= 2'd0;
            r_gnt      <= 3'b000;
            r_mem_en   <= 1'b0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_din  <= '0;
            r_rvalid   <= 3'b000;
        end else begin
            r_gnt    <= w_win_vld ? w_win_onehot : 3'b000;
            r_mem_en <= w_win_vld;
            r_mem_we <= w_win_vld & w_sel_we;
            if (w_win_vld) begin
                r_mem_addr <= w_sel_addr;
                r_mem_din  <= w_sel_wdata;
                r_ptr      <= w_ptr_nxt;
            end
            // The one-hot grant of a read issue doubles as the return tag for the next cycle.
            r_rvalid <= (r_mem_en && !r_mem_we) ? r_gnt : 3'b000;
        end
    end

    assign gnt      = r_gnt;
    assign rvalid   = r_rvalid;
    assign rdata    = mem_dout;
    assign mem_en   = r_mem_en;
    assign mem_we   = r_mem_we;
    assign mem_addr = r_mem_addr;
    assign mem_din  = r_mem_din;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural write-first RAM on port A.
module tb_mem_port_arbiter;

    localparam int W  = 16;
    localparam int AW = 15;

    logic          clk;
    logic          reset;
    logic [2:0]    req;
    logic [2:0]    req_we;
    logic [3*AW-1:0] req_addr;
    logic [3*W-1:0]  req_wdata;
    logic [2:0]    gnt;
    logic [2:0]    rvalid;
    logic [W-1:0]  rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [W-1:0]  mem_din;
    logic [W-1:0]  mem_dout;

    logic [W-1:0]  ram [0:(1<<AW)-1];
    logic          ld_en;
    logic [AW-1:0] ld_addr;
    logic [W-1:0]  ld_data;

    int n_checks;
    int n_errors;

    mem_port_arbiter #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ld_en) begin
            ram[ld_addr] <= ld_data;
        end else if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr] <= mem_din;
                mem_dout      <= mem_din;
            end else begin
                mem_dout <= ram[mem_addr];
            end
        end
    end

    typedef struct {
        logic [2:0]    req;
        logic [2:0]    we;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [W-1:0]  w1;
        logic [2:0]    gnt;
        logic          en;
        logic          mwe;
        logic [AW-1:0] maddr;
        logic [W-1:0]  mdin;
        logic [2:0]    rv;
        logic [W-1:0]  rd;
    } vec_t;

    vec_t vecs [0:21];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [2:0] r, input logic [2:0] we,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2, input logic [W-1:0] w1);
        req       = r;
        req_we    = we;
        req_addr  = {a2, a1, a0};
        req_wdata = {16'h0000, w1, 16'h0000};
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " gnt"},    32'(gnt),    32'h0);
        chk({tag, " rvalid"}, 32'(rvalid), 32'h0);
        chk({tag, " mem_en"}, 32'(mem_en), 32'h0);
        chk({tag, " mem_we"}, 32'(mem_we), 32'h0);
    endtask

    function automatic vec_t mk(input logic [2:0] r, input logic [2:0] we,
                                input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                                input logic [AW-1:0] a2, input logic [W-1:0] w1,
                                input logic [2:0] g, input logic en, input logic mwe,
                                input logic [AW-1:0] maddr, input logic [W-1:0] mdin,
                                input logic [2:0] rv, input logic [W-1:0] rd);
        vec_t v;
        v.req = r; v.we = we; v.a0 = a0; v.a1 = a1; v.a2 = a2; v.w1 = w1;
        v.gnt = g; v.en = en; v.mwe = mwe; v.maddr = maddr; v.mdin = mdin;
        v.rv = rv; v.rd = rd;
        return v;
    endfunction

    initial begin
        n_checks = 0;
        n_errors = 0;

        // Each row: inputs driven this cycle, outputs expected this same cycle (from last cycle's inputs).
        //              req     we      a0       a1       a2       w1        gnt    en    mwe   maddr    mdin      rv     rdata
        vecs[0]  = mk(3'b000, 3'b000, 15'h0000, 15'h0000, 15'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 15'h0000, 16'h0000, 3'b000, 16'h0000);
        vecs[1]  = mk(3'b001, 3'b000, 15'h0010, 15'h0000, 15'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 15'h0000, 16'h0000, 3'b000, 16'h0000);
        vecs[2]  = mk(3'b000, 3'b000, 15'h0010, 15'h0000, 15'h0000, 16'h0000, 3'b001, 1'b1, 1'b0, 15'h0010, 16'h0000, 3'b000, 16'h0000);
        vecs[3]  = mk(3'b000, 3'b000, 15'h0010, 15'h0000, 15'h0000, 16'h0000, 3'b000, 1'b0, 1'b0, 15'h0010, 16'h0000, 3'b001, 16'hBEEF);
        vecs[4]  = mk(3'b010, 3'b010, 15'h0010, 15'h2000, 15'h0000, 16'h1234, 3'b000, 1'b0, 1'b0, 15'h0010, 16'h0000, 3'b000, 16'h0000);
        vecs[5]  = mk(3'b100, 3'b000, 15'h0010, 15'h2000, 15'h2000, 16'h0000, 3'b010, 1'b1, 1'b1, 15'h2000, 16'h1234, 3'b000, 16'h0000);
        vecs[6]  = mk(3'b000, 3'b000, 15'h0010, 15'h2000, 15'h2000, 16'h0000, 3'b100, 1'b1, 1'b0, 15'h2000, 16'h0000, 3'b000, 16'h0000);
        vecs[7]  = mk(3'b000, 3'b000, 15'h0010, 15'h2000, 15'h2000, 16'h0000, 3'b000, 1'b0, 1'b0, 15'h2000, 16'h0000, 3'b100, 16'h1234);
        vecs[8]  = mk(3'b111, 3'b000, 15'h0000, 15'h7FFF, 15'h0010, 16'h0000, 3'b000, 1'b0, 1'b0, 15'h2000, 16'h0000, 3'b000, 16'h0000);
        vecs[9]  = mk(3'b111, 3'b000, 15'h0000, 15'h7FFF, 15'h0010, 16'h0000, 3'b001, 1'b1, 1'b0, 15'h0000, 16'h0000, 3'b000, 16'h0000);
        vecs[10] = mk(3'b111, 3'b000, 15'h0000, 15'h7FFF, 15'h0010, 16'h0000, 3'b010, 1'b1, 1'b0, 15'h7FFF, 16'h0000, 3'b001, 16'h0F0F);
        vecs[11] = mk(3'b111, 3'b000, 15'h0000, 15'h7FFF, 15'h0010, 16'h0000, 3'b100, 1'b1, 1'b0, 15'h0010, 16'h0000, 3'b010, 16'hA5A5);
        vecs[12] = mk(3'b111, 3'b000, 15'h0000, 15'h7FFF, 15'h0010, 16'h0000, 3'b001, 1'b1, 1'b0, 15'h0000, 16'h0000, 3'b100, 16'hBEEF);
        vecs[13] = mk(3'b111, 3'b000, 15'h0000, 15'h7FFF, 15'h0010, 16'h0000, 3'b010, 1'b1, 1'b0, 15'h7FFF, 16'h0000, 3'b001, 16'h0F0F);
        vecs[14] = mk(3'b000, 3'b000, 15'h0000, 15'h7FFF, 15'h0010, 16'h0000, 3'b100, 1'b1, 1'b0, 15'h0010, 16'h0000, 3'b010, 16'hA5A5);
        vecs[15] = mk(3'b000, 3'b000, 15'h0000, 15'h7FFF, 15'h0010, 16'h0000, 3'b000, 1'b0, 1'b0, 15'h0010, 16'h0000, 3'b100, 16'hBEEF);
        vecs[16] = mk(3'b100, 3'b000, 15'h0000, 15'h0000, 15'h7FFF, 16'h0000, 3'b000, 1'b0, 1'b0, 15'h0010, 16'h0000, 3'b000, 16'h0000);
        vecs[17] = mk(3'b100, 3'b000, 15'h0000, 15'h0000, 15'h7FFF, 16'h0000, 3'b100, 1'b1, 1'b0, 15'h7FFF, 16'h0000, 3'b000, 16'h0000);
        vecs[18] = mk(3'b100, 3'b000, 15'h0000, 15'h0000, 15'h7FFF, 16'h0000, 3'b000, 1'b0, 1'b0, 15'h7FFF, 16'h0000, 3'b100, 16'hA5A5);
        vecs[19] = mk(3'b100, 3'b000, 15'h0000, 15'h0000, 15'h7FFF, 16'h0000, 3'b100, 1'b1, 1'b0, 15'h7FFF, 16'h0000, 3'b000, 16'h0000);
        vecs[20] = mk(3'b000, 3'b000, 15'h0000, 15'h0000, 15'h7FFF, 16'h0000, 3'b000, 1'b0, 1'b0, 15'h7FFF, 16'h0000, 3'b100, 16'hA5A5);
        vecs[21] = mk(3'b000, 3'b000, 15'h0000, 15'h0000, 15'h7FFF, 16'h0000, 3'b000, 1'b0, 1'b0, 15'h7FFF, 16'h0000, 3'b000, 16'h0000);

        reset = 1'b0;
        ld_en = 1'b0;
        ld_addr = '0;
        ld_data = '0;
        drive(3'b000, 3'b000, 15'h0, 15'h0, 15'h0, 16'h0);

        // Hold reset for three cycles, using them to preload the RAM.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            ld_en   = 1'b1;
            ld_addr = (i == 0) ? 15'h0010 : (i == 1) ? 15'h7FFF : 15'h0000;
            ld_data = (i == 0) ? 16'hBEEF : (i == 1) ? 16'hA5A5 : 16'h0F0F;
            @(negedge clk);
            chk_idle("reset");
            chk("reset mem_addr", 32'(mem_addr), 32'h0);
            chk("reset mem_din",  32'(mem_din),  32'h0);
        end
        @(posedge clk); #1;
        ld_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 22; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].req, vecs[i].we, vecs[i].a0, vecs[i].a1, vecs[i].a2, vecs[i].w1);
            @(negedge clk);
            chk($sformatf("v%0d gnt", i),      32'(gnt),      32'(vecs[i].gnt));
            chk($sformatf("v%0d mem_en", i),   32'(mem_en),   32'(vecs[i].en));
            chk($sformatf("v%0d mem_we", i),   32'(mem_we),   32'(vecs[i].mwe));
            chk($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].maddr));
            chk($sformatf("v%0d mem_din", i),  32'(mem_din),  32'(vecs[i].mdin));
            chk($sformatf("v%0d rvalid", i),   32'(rvalid),   32'(vecs[i].rv));
            if (vecs[i].rv != 3'b000)
                chk($sformatf("v%0d rdata", i), 32'(rdata), 32'(vecs[i].rd));
        end

        // Reset asserted in the cycle the read data would come back; rvalid must never appear.
        @(posedge clk); #1;
        drive(3'b001, 3'b000, 15'h0010, 15'h0000, 15'h0000, 16'h0000);
        @(negedge clk);
        chk("rst-mid pre gnt", 32'(gnt), 32'h0);
        @(posedge clk); #1;
        drive(3'b000, 3'b000, 15'h0010, 15'h0000, 15'h0000, 16'h0000);
        @(negedge clk);
        chk("rst-mid gnt", 32'(gnt), 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rst-mid async rvalid", 32'(rvalid), 32'h0);
        @(negedge clk);
        chk_idle("rst-mid hold");
        @(negedge clk);
        chk_idle("rst-mid hold2");
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst-mid post rvalid", 32'(rvalid), 32'h0);
        end

        // Pointer must be back at 0: with 0 and 1 requesting, 0 wins first, then 1.
        @(posedge clk); #1;
        drive(3'b011, 3'b000, 15'h0000, 15'h7FFF, 15'h0000, 16'h0000);
        @(negedge clk);
        chk("ptr0 pre gnt", 32'(gnt), 32'h0);
        @(posedge clk); #1;
        drive(3'b010, 3'b000, 15'h0000, 15'h7FFF, 15'h0000, 16'h0000);
        @(negedge clk);
        chk("ptr0 first gnt", 32'(gnt), 32'h1);
        @(posedge clk); #1;
        drive(3'b000, 3'b000, 15'h0000, 15'h7FFF, 15'h0000, 16'h0000);
        @(negedge clk);
        chk("ptr0 second gnt", 32'(gnt),    32'h2);
        chk("ptr0 rvalid",     32'(rvalid), 32'h1);
        chk("ptr0 rdata",      32'(rdata),  32'h0F0F);
        @(negedge clk);
        chk("ptr0 rvalid2",    32'(rvalid), 32'h2);
        chk("ptr0 rdata2",     32'(rdata),  32'hA5A5);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
